// File: rtl/dp_mem_responder.sv
// Responder side of the datapath/cache interface. Arbitrates instruction fetches against data
// loads/stores, runs one single-ported RAM access at a time over the ramstate handshake and
// returns single-cycle ihit/dhit pulses with the load data. A halt parks the block in a sticky
// flushed state that only reset leaves.
// Optional feature: define DP_MEM_IBUF_EN for a one-entry fetch buffer that serves repeat
// fetches of the same address in IDLE without touching the RAM.
module dp_mem_responder #(
  parameter int unsigned DATA_PRIORITY = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  // ramstate_t encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3; only ACCESS completes an access.
  localparam logic [1:0] RamAccess = 2'd2;

  typedef enum logic [1:0] {StIdle, StDreq, StIreq, StHalted} state_e;

  state_e state_q, state_d;

  logic        d_req;
  logic        d_wins;
  logic        ram_done;
  logic        ibuf_hit;
  logic [31:0] ibuf_data;

  assign d_req    = dmemREN | dmemWEN;
  // With DATA_PRIORITY=0 a data request only wins when no fetch is pending.
  assign d_wins   = d_req && ((DATA_PRIORITY != 0) || !imemREN);
  assign ram_done = (ramstate == RamAccess);

`ifdef DP_MEM_IBUF_EN
  logic        ibuf_valid_q, ibuf_valid_d;
  logic [31:0] ibuf_addr_q, ibuf_addr_d;
  logic [31:0] ibuf_data_q, ibuf_data_d;

  assign ibuf_hit  = ibuf_valid_q && (imemaddr == ibuf_addr_q);
  assign ibuf_data = ibuf_data_q;

  // Fill on every completed fetch; a completed store to the buffered address invalidates it.
  always_comb begin
    ibuf_valid_d = ibuf_valid_q;
    ibuf_addr_d  = ibuf_addr_q;
    ibuf_data_d  = ibuf_data_q;
    if (state_q == StIreq && ram_done) begin
      ibuf_valid_d = 1'b1;
      ibuf_addr_d  = imemaddr;
      ibuf_data_d  = ramload;
    end else if (state_q == StDreq && ram_done && dmemWEN && (dmemaddr == ibuf_addr_q)) begin
      ibuf_valid_d = 1'b0;
    end
  end

  // Fetch buffer registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ibuf_valid_q <= 1'b0;
      ibuf_addr_q  <= '0;
      ibuf_data_q  <= '0;
    end else begin
      ibuf_valid_q <= ibuf_valid_d;
      ibuf_addr_q  <= ibuf_addr_d;
      ibuf_data_q  <= ibuf_data_d;
    end
  end
`else
  assign ibuf_hit  = 1'b0;
  assign ibuf_data = '0;
`endif

  // Next state and all outputs; RAM strobes depend only on state so reset drops them at once.
  always_comb begin
    state_d  = state_q;
    ihit     = 1'b0;
    imemload = '0;
    dhit     = 1'b0;
    dmemload = '0;
    flushed  = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      StIdle: begin
        if (halt) begin
          state_d = StHalted;
        end else if (d_wins) begin
          state_d = StDreq;
        end else if (imemREN) begin
          if (ibuf_hit) begin
            ihit     = 1'b1;
            imemload = ibuf_data;
          end else begin
            state_d = StIreq;
          end
        end
      end
      StDreq: begin
        ramaddr  = dmemaddr;
        ramREN   = dmemREN;
        ramWEN   = dmemWEN;
        ramstore = dmemstore;
        // BUSY/FREE/ERROR all hold the request; ERROR is simply retried.
        if (ram_done) begin
          dhit     = 1'b1;
          dmemload = ramload;
          state_d  = StIdle;
        end
      end
      StIreq: begin
        ramaddr = imemaddr;
        ramREN  = 1'b1;
        if (ram_done) begin
          ihit     = 1'b1;
          imemload = ramload;
          state_d  = StIdle;
        end
      end
      StHalted: begin
        flushed = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_dp_mem_responder.sv
// Bench for dp_mem_responder: a RAM environment model, a driver that behaves like the datapath,
// and a scoreboard monitor that checks every hit against a reference memory image.
module tb_dp_mem_responder;
  localparam int unsigned DP = 1;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        halt = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        dmemREN = 1'b0;
  logic        dmemWEN = 1'b0;
  logic [31:0] dmemaddr = '0;
  logic [31:0] dmemstore = '0;
  logic        ihit, dhit, flushed, ramREN, ramWEN;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = 2'd0;

  dp_mem_responder #(.DATA_PRIORITY(DP)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Initial memory contents rule shared by the RAM environment and the reference image.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  // ---------------- RAM environment ----------------
  logic [31:0] ram_mem [logic [31:0]];
  int lat_fixed = -1;
  bit err_en = 1'b1;
  int ram_cnt = 0;
  bit ram_busy = 1'b0;

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
  endfunction

  // Responds on the falling edge: ram_cnt wait cycles (BUSY or ERROR) then one ACCESS cycle.
  always @(negedge CLK or negedge nRST) begin
    if (!nRST) begin
      ram_busy = 1'b0;
      ramstate = 2'd0;
      ramload  = '0;
    end else if (ramREN || ramWEN) begin
      if (!ram_busy) begin
        ram_busy = 1'b1;
        ram_cnt  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
      end
      if (ram_cnt == 0) begin
        ramstate = 2'd2;
        ramload  = ram_rd(ramaddr);
        if (ramWEN) ram_mem[ramaddr] = ramstore;
        ram_busy = 1'b0;
      end else begin
        ramstate = (err_en && ($urandom_range(0, 1) == 1)) ? 2'd3 : 2'd1;
        ramload  = $urandom;
        ram_cnt--;
      end
    end else begin
      ramstate = 2'd0;
      ram_busy = 1'b0;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  typedef struct {
    bit          is_d;
    bit          is_st;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  bit mon_en = 1'b0;

  // Monitor: every hit pops the next expected response in service order.
  always @(negedge CLK) begin
    #2;
    if (mon_en && nRST === 1'b1 && (ihit || dhit)) begin
      check("one_hit_per_cycle", 32'(ihit & dhit), 32'd0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_hit: ihit=%0b dhit=%0b with nothing outstanding", ihit, dhit);
      end else begin
        e = sbq.pop_front();
        check("hit_kind_is_d", 32'(dhit), 32'(e.is_d));
        if (ramREN || ramWEN) check("hit_ramaddr", ramaddr, e.addr);
        if (e.is_d) check("hit_ramWEN", 32'(ramWEN), 32'(e.is_st));
        if (!e.is_st) begin
          if (e.is_d) check("dmemload", dmemload, e.data);
          else        check("imemload", imemload, e.data);
        end
      end
    end
  end

  task automatic push_d(input bit wr, input logic [31:0] a, input logic [31:0] sd);
    if (wr) begin
      ref_mem[a] = sd;
      sbq.push_back('{is_d: 1'b1, is_st: 1'b1, addr: a, data: sd});
    end else begin
      sbq.push_back('{is_d: 1'b1, is_st: 1'b0, addr: a, data: ref_rd(a)});
    end
  endtask

  // Datapath-like driver: raise requests, drop each one right after its hit.
  task automatic run_op(input bit do_i, input bit do_d, input bit d_wr, input logic [31:0] ia,
                        input logic [31:0] da, input logic [31:0] sd,
                        output int cycles, output bit saw_ram);
    bit i_done, d_done, d_first;
    d_first = do_d && ((DP != 0) || !do_i);
    if (d_first) push_d(d_wr, da, sd);
    if (do_i) sbq.push_back('{is_d: 1'b0, is_st: 1'b0, addr: ia, data: ref_rd(ia)});
    if (do_d && !d_first) push_d(d_wr, da, sd);
    @(posedge CLK); #1;
    imemREN   = do_i;
    imemaddr  = ia;
    dmemREN   = do_d && !d_wr;
    dmemWEN   = do_d && d_wr;
    dmemaddr  = da;
    dmemstore = sd;
    i_done  = !do_i;
    d_done  = !do_d;
    cycles  = 0;
    saw_ram = 1'b0;
    while (!(i_done && d_done) && cycles < 60) begin
      @(negedge CLK); #3;
      cycles++;
      if (ramREN || ramWEN) saw_ram = 1'b1;
      if (ihit) i_done = 1'b1;
      if (dhit) d_done = 1'b1;
      if (ihit || dhit) begin
        @(posedge CLK); #1;
        if (i_done) imemREN = 1'b0;
        if (d_done) begin
          dmemREN = 1'b0;
          dmemWEN = 1'b0;
        end
      end
    end
    if (!(i_done && d_done)) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: i_done=%0b d_done=%0b after %0d cycles", i_done, d_done, cycles);
      imemREN = 1'b0;
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
      sbq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  cyc, n, kind;
    bit  saw;
    logic [31:0] a1, a2, sd;

    // Reset values.
    #12;
    check("rst_ihit", 32'(ihit), 32'd0);
    check("rst_dhit", 32'(dhit), 32'd0);
    check("rst_imemload", imemload, 32'd0);
    check("rst_dmemload", dmemload, 32'd0);
    check("rst_flushed", 32'(flushed), 32'd0);
    check("rst_ram_strobes", 32'({ramREN, ramWEN}), 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    @(posedge CLK); #1 nRST = 1'b1;

    // Reset in the middle of a fetch drops the RAM strobe without waiting for a clock.
    lat_fixed = 5;
    err_en    = 1'b0;
    @(posedge CLK); #1;
    imemREN  = 1'b1;
    imemaddr = 32'h20;
    n = 0;
    do begin
      @(negedge CLK); #3;
      n++;
    end while (!ramREN && n < 10);
    check("midreq_ramREN_seen", 32'(ramREN), 32'd1);
    nRST = 1'b0;
    #1;
    check("midreq_rst_ramREN", 32'(ramREN), 32'd0);
    check("midreq_rst_ihit", 32'(ihit), 32'd0);
    check("midreq_rst_flushed", 32'(flushed), 32'd0);
    check("midreq_rst_ramaddr", ramaddr, 32'd0);
    imemREN = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK); #3;
    check("post_rst_idle_ramREN", 32'(ramREN), 32'd0);

    mon_en = 1'b1;

    // Fetch 0x0: two BUSY cycles then ACCESS.
    ram_mem[32'h0] = 32'h8C01_0004;
    ref_mem[32'h0] = 32'h8C01_0004;
    lat_fixed = 2;
    run_op(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, cyc, saw);
    check("fetch0_latency", 32'(cyc), 32'd4);
    @(negedge CLK); #3;
    check("fetch0_ihit_pulse_gone", 32'(ihit), 32'd0);

    // Simultaneous fetch and load of 0x100: data first, then the fetch.
    lat_fixed = -1;
    err_en    = 1'b1;
    run_op(1'b1, 1'b1, 1'b0, 32'h100, 32'h100, 32'h0, cyc, saw);

    // Store to 0x80: strobes and data held through the wait states, then dhit.
    lat_fixed = 3;
    push_d(1'b1, 32'h80, 32'hDEAD_BEEF);
    @(posedge CLK); #1;
    dmemWEN   = 1'b1;
    dmemaddr  = 32'h80;
    dmemstore = 32'hDEAD_BEEF;
    n = 0;
    while (n < 20) begin
      @(negedge CLK); #3;
      n++;
      if (ramREN || ramWEN || dhit) begin
        check("st_ramWEN", 32'(ramWEN), 32'd1);
        check("st_ramREN", 32'(ramREN), 32'd0);
        check("st_ramaddr", ramaddr, 32'h80);
        check("st_ramstore", ramstore, 32'hDEAD_BEEF);
      end
      if (dhit) break;
    end
    check("st_dhit", 32'(dhit), 32'd1);
    @(posedge CLK); #1 dmemWEN = 1'b0;
    run_op(1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0, cyc, saw);

    // Randomized traffic against the reference image.
    lat_fixed = -1;
    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 4));
      a1 = 32'($urandom_range(0, 15)) << 2;
      a2 = 32'($urandom_range(0, 15)) << 2;
      sd = $urandom;
      case (kind)
        0: run_op(1'b1, 1'b0, 1'b0, a1, a2, sd, cyc, saw);
        1: run_op(1'b0, 1'b1, 1'b0, a1, a2, sd, cyc, saw);
        2: run_op(1'b0, 1'b1, 1'b1, a1, a2, sd, cyc, saw);
        3: run_op(1'b1, 1'b1, 1'b0, a1, a2, sd, cyc, saw);
        default: run_op(1'b1, 1'b1, 1'b1, a1, a2, sd, cyc, saw);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end
    @(negedge CLK); #3;
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

`ifdef DP_MEM_IBUF_EN
    // Repeat fetch hits the buffer; a store to that address forces a real fetch again.
    run_op(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, cyc, saw);
    run_op(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, cyc, saw);
    check("ibuf_hit_latency", 32'(cyc), 32'd1);
    check("ibuf_hit_no_ram", 32'(saw), 32'd0);
    run_op(1'b0, 1'b1, 1'b1, 32'h0, 32'h40, 32'h1234_5678, cyc, saw);
    run_op(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, cyc, saw);
    check("ibuf_inval_refetch", 32'(saw), 32'd1);
`endif

    // Halt during a load: the load completes, then flushed stays up with no RAM traffic.
    lat_fixed = 3;
    push_d(1'b0, 32'h10, 32'h0);
    @(posedge CLK); #1;
    dmemREN  = 1'b1;
    dmemaddr = 32'h10;
    n = 0;
    do begin
      @(negedge CLK); #3;
      n++;
    end while (!ramREN && n < 10);
    @(posedge CLK); #1 halt = 1'b1;
    n = 0;
    do begin
      @(negedge CLK); #3;
      n++;
    end while (!dhit && n < 20);
    check("halt_load_dhit", 32'(dhit), 32'd1);
    @(posedge CLK); #1;
    dmemREN  = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h48;
    dmemWEN  = 1'b1;
    dmemaddr = 32'h44;
    @(posedge CLK);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK); #3;
      check("halted_flushed", 32'(flushed), 32'd1);
      check("halted_no_strobes", 32'({ramREN, ramWEN}), 32'd0);
    end
    mon_en = 1'b0;
    nRST = 1'b0;
    halt = 1'b0;
    imemREN = 1'b0;
    dmemWEN = 1'b0;
    #1;
    check("halt_reset_flushed", 32'(flushed), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
